// File: rtl/console_slave_pkg.sv
// console_slave_pkg: shared constants, state type and helpers for the
// console bus register responder.
//   STATUS_ID          - fixed identity in STATUS[31:16]
//   STATUS_*_BIT       - sticky error bit positions in STATUS
//   DECERR_DATA        - read data returned for out-of-range reads
//   state_e            - responder state (INIT, READY)
//   be_merge()         - byte-lane write merge
package console_slave_pkg;

  localparam logic [15:0] STATUS_ID          = 16'hC05E;
  localparam int          STATUS_DECERR_BIT  = 0;
  localparam int          STATUS_PROTERR_BIT = 1;
  localparam logic [31:0] DECERR_DATA        = 32'hDEAD_BEEF;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] result;
    result = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        result[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        result[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/console_slave_if.sv
// console_slave_if: Avalon-MM pipelined bus between the console master and
// the register responder.
//   address[31:0]      master -> slave  byte address
//   byteenable[3:0]    master -> slave  write lanes
//   read, write        master -> slave  requests
//   writedata[31:0]    master -> slave  write data
//   readdata[31:0]     slave -> master  read data (0 unless readdatavalid)
//   readdatavalid      slave -> master  one strobe per accepted read
//   waitrequest        slave -> master  request not accepted this cycle
interface console_slave_if;

  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/console_slave_rdpipe.sv
// console_slave_rdpipe: fixed-latency delay line for read responses.
//   clk, reset         clock and synchronous active-high flush
//   in_valid, in_data  response captured at the acceptance edge
//   out_valid, out_data response after READ_LATENCY edges
// Data is stored as zero in invalid slots so out_data is 0 whenever
// out_valid is low.
module console_slave_rdpipe #(
  parameter int READ_LATENCY = 2,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [READ_LATENCY-1:0] vld_r;
  logic [DATA_W-1:0]       dat_r [READ_LATENCY];

  // Shift valid/data pairs one stage per clock; reset drops everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_r[i] <= 1'b0;
        dat_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      vld_r[0] <= in_valid;
      dat_r[0] <= in_valid ? in_data : {DATA_W{1'b0}};
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        dat_r[i] <= dat_r[i-1];
      end
    end
  end

  assign out_valid = vld_r[READ_LATENCY-1];
  assign out_data  = dat_r[READ_LATENCY-1];

endmodule

// File: rtl/console_slave_regs.sv
// console_slave_regs: Avalon-MM pipelined responder with a small 32-bit
// register bank. Word 0 is STATUS (ID plus sticky DECERR/PROTERR, W1C),
// words 1..NUM_REGS-1 are byte-enabled scratch registers.
//   clk    sole clock, rising edge
//   reset  synchronous, active-high
//   bus    console_slave_if.slave
// Optional feature macro: CONSOLE_SLAVE_TIMESTAMP_EN adds a free-running
// 32-bit counter at word NUM_REGS (writes clear it).
module console_slave_regs
  import console_slave_pkg::*;
#(
  parameter int          NUM_REGS     = 8,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] RESET_VALUE  = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  console_slave_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REGS);
`ifdef CONSOLE_SLAVE_TIMESTAMP_EN
  localparam logic [29:0] WORD_LIMIT = 30'(NUM_REGS + 1);
`else
  localparam logic [29:0] WORD_LIMIT = 30'(NUM_REGS);
`endif

  state_e      state_r;
  logic        waitrequest_r;
  logic [31:0] regs_r [1:NUM_REGS-1];
  logic        decerr_r;
  logic        proterr_r;

  logic [29:0]      word_s;
  logic [IDX_W-1:0] idx_s;
  logic             in_range_s;
  logic             ts_hit_s;
  logic             accept_s;
  logic             wr_ok_s;
  logic             rd_issue_s;
  logic             stat_clr_s;
  logic             decerr_set_s;
  logic             proterr_set_s;
  logic [31:0]      status_s;
  logic [31:0]      rd_data_s;
  logic             unused_s;

  assign word_s     = bus.address[31:2];
  assign idx_s      = bus.address[IDX_W+1:2];
  assign in_range_s = (word_s < WORD_LIMIT);
  assign unused_s   = ^bus.address[1:0];

  // A request is only taken while waitrequest is low.
  assign accept_s   = (bus.read | bus.write) & ~waitrequest_r;
  // Write wins on read+write; the read half is discarded.
  assign wr_ok_s    = accept_s & bus.write & in_range_s;
  assign rd_issue_s = accept_s & bus.read & ~bus.write;

  assign decerr_set_s  = accept_s & ~in_range_s;
  assign proterr_set_s = accept_s & bus.read & bus.write;
  assign stat_clr_s    = wr_ok_s & ~ts_hit_s & (idx_s == {IDX_W{1'b0}}) & bus.byteenable[0];

`ifdef CONSOLE_SLAVE_TIMESTAMP_EN
  logic [31:0] ts_r;

  // ts_hit_s: the timestamp word aliases index 0, so it is decoded separately.
  assign ts_hit_s = (word_s == 30'(NUM_REGS));

  // Free-running counter; a write with any lane enabled restarts it at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_r <= 32'h0000_0000;
    end else if (wr_ok_s && ts_hit_s && (bus.byteenable != 4'b0000)) begin
      ts_r <= 32'h0000_0000;
    end else begin
      ts_r <= ts_r + 32'h0000_0001;
    end
  end
`else
  assign ts_hit_s = 1'b0;
`endif

  // Assemble the STATUS word from ID and sticky bits.
  always_comb begin
    status_s = {STATUS_ID, 16'h0000};
    status_s[STATUS_DECERR_BIT]  = decerr_r;
    status_s[STATUS_PROTERR_BIT] = proterr_r;
  end

  // Read mux, sampled at the acceptance edge (before that edge's write).
  always_comb begin
    rd_data_s = 32'h0000_0000;
    if (!in_range_s) begin
      rd_data_s = DECERR_DATA;
    end else if (ts_hit_s) begin
`ifdef CONSOLE_SLAVE_TIMESTAMP_EN
      rd_data_s = ts_r;
`else
      rd_data_s = DECERR_DATA;
`endif
    end else if (idx_s == {IDX_W{1'b0}}) begin
      rd_data_s = status_s;
    end else begin
      rd_data_s = regs_r[idx_s];
    end
  end

  // Two-state control: one INIT cycle after reset, then READY forever.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= INIT;
      waitrequest_r <= 1'b1;
    end else begin
      case (state_r)
        INIT: begin
          state_r       <= READY;
          waitrequest_r <= 1'b0;
        end
        READY: begin
          state_r       <= READY;
          waitrequest_r <= 1'b0;
        end
        default: begin
          state_r       <= INIT;
          waitrequest_r <= 1'b1;
        end
      endcase
    end
  end

  // Scratch registers with byte-lane writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_r[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_ok_s && !ts_hit_s && (idx_s == IDX_W'(i))) begin
          regs_r[i] <= be_merge(regs_r[i], bus.writedata, bus.byteenable);
        end
      end
    end
  end

  // Sticky error bits: write-1-to-clear, a same-cycle set takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      decerr_r  <= 1'b0;
      proterr_r <= 1'b0;
    end else begin
      decerr_r  <= (decerr_r  & ~(stat_clr_s & bus.writedata[STATUS_DECERR_BIT]))  | decerr_set_s;
      proterr_r <= (proterr_r & ~(stat_clr_s & bus.writedata[STATUS_PROTERR_BIT])) | proterr_set_s;
    end
  end

  console_slave_rdpipe #(
    .READ_LATENCY (READ_LATENCY),
    .DATA_W       (32)
  ) u_rdpipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_issue_s),
    .in_data   (rd_data_s),
    .out_valid (bus.readdatavalid),
    .out_data  (bus.readdata)
  );

  assign bus.waitrequest = waitrequest_r;

endmodule

// File: doc/console_slave_regs.md
# console_slave_regs

Avalon-MM pipelined responder holding a small 32-bit register bank, with fixed-latency reads and byte-enabled writes. It is the slave-side counterpart of the JTAG console master and sits on the console bus as the master's default target. Host tooling uses it for scratch, status and diagnostics. It accepts one transfer per cycle once initialised and records protocol and decode errors in a sticky status register.

## Interface
- NUM_REGS, 8, number of 32-bit words; power of two, 2..16; word 0 is STATUS
- READ_LATENCY, 2, cycles from read acceptance to readdatavalid; 1..4
- RESET_VALUE, 32'h0000_0000, reset contents of words 1..NUM_REGS-1
- clk  in  1  sole clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- address  in  32  byte address; bits [1:0] ignored
- byteenable  in  4  write byte lanes; ignored for reads
- read  in  1  read request
- write  in  1  write request
- writedata  in  32  write data
- readdata  out  32  read data, valid only with readdatavalid
- readdatavalid  out  1  one-cycle strobe per accepted read
- waitrequest  out  1  high = request not accepted this cycle

## Operation
- Word index is address[2+log2(NUM_REGS)-1:2]. Address is in range when address[31:2] < NUM_REGS (NUM_REGS+1 with the timestamp option).
- States:
  - INIT: in reset and for the first cycle after reset deasserts; waitrequest=1.
  - READY: waitrequest=0.
  - INIT→READY is unconditional after one cycle. READY→INIT only through reset.
- Accept: (read|write) && !waitrequest in READY.
- STATUS (word 0):
  - [31:16] = 16'hC05E, read-only.
  - bit0 DECERR: sticky; set on an out-of-range access.
  - bit1 PROTERR: sticky; set when read and write are asserted together.
  - Write-1-to-clear on bits 0/1 when byteenable[0]=1. Other bits read 0.
- Words 1..NUM_REGS-1: read/write. Byte lane i is updated only when byteenable[i]=1.
- Out-of-range write: dropped; DECERR set. Out-of-range read: returns 32'hDEAD_BEEF; DECERR set; readdatavalid still produced.
- Simultaneous read+write: the write is performed, the read is discarded (no readdatavalid), PROTERR set.
- If a clear and a set of the same STATUS bit hit the same cycle, the set wins.
- Read data is sampled at the acceptance edge. A write accepted at edge k is visible to a read accepted at edge k+1.

## Timing
- Reset values:
  - readdata=0, readdatavalid=0, waitrequest=1.
  - STATUS error bits=0; words 1..N-1=RESET_VALUE.
  - Read pipeline flushed.
- A read accepted at edge k drives readdatavalid=1 and readdata during the cycle after edge k+READ_LATENCY-1. Latency 1 means valid in the cycle immediately after acceptance.
- Full throughput: one read per cycle. Responses return in order, with no bubbles inserted.
- Writes take effect at the acceptance edge. There is no write response.
- Reset mid-operation: all in-flight reads are dropped. readdatavalid is 0 from the cycle after the reset edge, and no stale responses appear after INIT.
- readdata returns to 0 in any cycle where readdatavalid=0.

## Configuration
- CONSOLE_SLAVE_TIMESTAMP_EN defined:
  - Adds a 32-bit free-running counter at word NUM_REGS.
  - Reset value 0; increments every clk and wraps 32'hFFFF_FFFF→0.
  - A read returns the count at the acceptance edge. A write with any byteenable set clears it to 0 on the next edge.
  - The word counts as in range.
- Undefined: no counter; word NUM_REGS is out of range (DECERR, DEAD_BEEF).

## Structure
- Package console_slave_pkg:
  - STATUS_ID=16'hC05E; STATUS_DECERR_BIT=0; STATUS_PROTERR_BIT=1.
  - DECERR_DATA=32'hDEAD_BEEF.
  - State typedef {INIT, READY}.
- Sub-module console_slave_rdpipe: parameterised READ_LATENCY delay line carrying {valid, data}, with synchronous flush on reset.

## Test plan
- Reset then idle:
  - waitrequest=1 through reset plus one cycle, then 0.
  - A read of word 0 returns 32'hC05E_0000 after READ_LATENCY cycles.
- Write 32'hA5A5_A5A5 to word 3, then write 32'h1234_5678 with byteenable=4'b0101; read word 3 → 32'hA534_A578.
- Back-to-back reads of words 1,2,3,1 with READ_LATENCY=3 → four consecutive readdatavalid pulses, in order, starting 3 cycles after the first acceptance.
- Error paths:
  - Read of address 32'h0000_0100 → DEAD_BEEF; then STATUS reads 32'hC05E_0001.
  - Write 32'h1 to STATUS → STATUS reads 32'hC05E_0000.
  - read=write=1 to word 2 with 32'h77 → word 2=32'h77, no readdatavalid, PROTERR=1.
- Reset asserted with two reads in flight → no readdatavalid after reset; registers return to RESET_VALUE.
- With CONSOLE_SLAVE_TIMESTAMP_EN:
  - Two reads of word NUM_REGS, 10 cycles apart, differ by exactly 10.
  - A write clears the counter; the next read returns the elapsed cycles since the clear.
